trng_conditioner: RTL and testbench

Parametrised true-random-number source replacing the single-oscillator, single-bit output path. Collects `N_OSC` free-running ring-oscillator outputs, synchronises and XOR-combines them, samples at a programmable rate and optionally applies von Neumann debiasing. Packs the bits into `WORD_W`-bit words behind a valid/ready handshake. A repetition-count health test sits on the raw sample stream. Instantiated in the chip top between the oscillator bank and the user output pins.

---
 rtl/trng_conditioner_pkg.sv | 16 +
 rtl/trng_conditioner_if.sv | 15 +
 rtl/trng_conditioner_sync.sv | 36 +++
 rtl/trng_conditioner.sv | 199 +++++++++++++++++++
 tb/tb_trng_conditioner.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/trng_conditioner_pkg.sv
// trng_pkg: shared types and constants for the TRNG conditioner.
//   vn_state_t  - von Neumann debias FSM state (VN_EMPTY / VN_HAVE)
//   trng_mode_t - conditioning mode select, with constants MODE_RAW and MODE_VN
package trng_pkg;

  typedef enum logic [0:0] {
    VN_EMPTY = 1'b0,
    VN_HAVE  = 1'b1
  } vn_state_t;

  typedef logic trng_mode_t;

  localparam trng_mode_t MODE_RAW = 1'b0;  // every XOR sample is emitted
  localparam trng_mode_t MODE_VN  = 1'b1;  // von Neumann debiased pairs

endpackage

// File: rtl/trng_conditioner_if.sv
// trng_conditioner_if: valid/ready word stream out of the TRNG conditioner.
//   data  - random word, held stable while valid is high and ready is low
//   valid - data holds an unconsumed word
//   ready - consumer accepts data on a cycle where valid && ready
// Modports: master (the conditioner) and slave (the consumer).
interface trng_conditioner_if #(
  parameter int WORD_W = 8
);
  logic [WORD_W-1:0] data;
  logic              valid;
  logic              ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/trng_conditioner_sync.sv
// trng_sync: parametrised-width two-flop synchroniser for signals that are
// asynchronous to clk. Every bit is resynchronised independently.
//   clk   - destination clock
//   rst_n - asynchronous active-low reset, clears both flop stages
//   d     - asynchronous input bits
//   q     - synchronised bits, two clk edges behind d
module trng_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_d, meta_q;
  logic [WIDTH-1:0] sync_d, sync_q;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/trng_conditioner.sv
// trng_conditioner: combines N_OSC free-running ring oscillators into a
// random word stream. The synchronised oscillator bits are XORed, sampled
// once every SAMPLE_DIV cycles, optionally von Neumann debiased, and packed
// MSB-first into WORD_W-bit words. A repetition-count health test watches
// the raw samples and blocks output while it is tripped.
//   clk         - system clock
//   rst_n       - asynchronous active-low reset
//   ena         - sampling enable; low freezes sampling/collection state
//   osc_in      - raw oscillator outputs (asynchronous)
//   mode        - MODE_RAW or MODE_VN
//   clear_fail  - one-cycle pulse clearing the health failure
//   health_fail - sticky repetition-test failure
//   out_if      - word stream (data/valid out, ready in)
module trng_conditioner
  import trng_pkg::*;
#(
  parameter int N_OSC      = 4,
  parameter int WORD_W     = 8,
  parameter int SAMPLE_DIV = 16,
  parameter int REP_LIMIT  = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  input  logic [N_OSC-1:0]       osc_in,
  input  trng_mode_t             mode,
  input  logic                   clear_fail,
  output logic                   health_fail,
  trng_conditioner_if.master     out_if
);

  localparam int CNT_W = $clog2(SAMPLE_DIV);
  localparam int REP_W = $clog2(REP_LIMIT + 1);
  localparam int BIT_W = $clog2(WORD_W + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);
  localparam logic [REP_W-1:0] REP_MAX  = REP_W'(REP_LIMIT);
  localparam logic [BIT_W-1:0] BIT_FULL = BIT_W'(WORD_W);

  // Repetition count saturates at the trip limit so it cannot wrap back
  // below the threshold during a long stuck run.
  function automatic logic [REP_W-1:0] rep_sat_inc(input logic [REP_W-1:0] v);
    if (v >= REP_MAX) return REP_MAX;
    return v + REP_W'(1);
  endfunction

  logic [N_OSC-1:0]  osc_sync;
  logic              raw_bit;
  logic              strobe;
  logic              mode_chg;
  logic              emit;
  logic              emit_bit;
  logic [WORD_W-1:0] shreg_nxt;
  logic [BIT_W-1:0]  bit_cnt_nxt;

  logic [CNT_W-1:0]  smp_cnt_d,     smp_cnt_q;
  logic              prev_d,        prev_q;
  logic [REP_W-1:0]  rep_cnt_d,     rep_cnt_q;
  logic              health_fail_d, health_fail_q;
  trng_mode_t        mode_d,        mode_q;
  vn_state_t         vn_state_d,    vn_state_q;
  logic              first_d,       first_q;
  logic [WORD_W-1:0] shreg_d,       shreg_q;
  logic [BIT_W-1:0]  bit_cnt_d,     bit_cnt_q;
  logic [WORD_W-1:0] data_d,        data_q;
  logic              valid_d,       valid_q;

  // Oscillator bits -> clk domain (2-cycle latency to raw_bit)
  trng_sync #(.WIDTH(N_OSC)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (osc_in),
    .q     (osc_sync)
  );

  assign raw_bit = ^osc_sync;

  // Sample timing and repetition health test
  always_comb begin
    strobe   = ena && (smp_cnt_q == CNT_LAST);
    mode_chg = (mode != mode_q);
    mode_d   = mode;

    smp_cnt_d = smp_cnt_q;
    if (ena) smp_cnt_d = strobe ? '0 : smp_cnt_q + CNT_W'(1);

    prev_d        = prev_q;
    rep_cnt_d     = rep_cnt_q;
    health_fail_d = health_fail_q;
    if (strobe) begin
      prev_d = raw_bit;
      // A zero count means no valid previous sample (after reset or clear),
      // so the first sample always starts a fresh run of length one.
      if ((rep_cnt_q != '0) && (raw_bit == prev_q)) rep_cnt_d = rep_sat_inc(rep_cnt_q);
      else rep_cnt_d = REP_W'(1);
      if (rep_cnt_d == REP_MAX) health_fail_d = 1'b1;
    end
    // Clearing wins over a failure tripping in the same cycle.
    if (clear_fail) begin
      health_fail_d = 1'b0;
      rep_cnt_d     = '0;
    end
  end

  // Bit extraction: raw pass-through or von Neumann pairing
  always_comb begin
    vn_state_d = vn_state_q;
    first_d    = first_q;
    emit       = 1'b0;
    emit_bit   = raw_bit;
    // A sample landing on the mode-change cycle belongs to neither mode
    // and is discarded along with the flush.
    if (strobe && !mode_chg) begin
      case (mode)
        MODE_RAW: emit = 1'b1;
        MODE_VN: begin
          if (vn_state_q == VN_EMPTY) begin
            first_d    = raw_bit;
            vn_state_d = VN_HAVE;
          end else begin
            // 10 -> 1, 01 -> 0: the emitted bit is the first of the pair.
            emit       = (first_q != raw_bit);
            emit_bit   = first_q;
            vn_state_d = VN_EMPTY;
          end
        end
      endcase
    end
    if (mode_chg || clear_fail) vn_state_d = VN_EMPTY;
  end

  // Word packing and output handshake
  always_comb begin
    shreg_nxt   = shreg_q;
    bit_cnt_nxt = bit_cnt_q;
    if (emit && (bit_cnt_q != BIT_FULL)) begin
      shreg_nxt   = {shreg_q[WORD_W-2:0], emit_bit};
      bit_cnt_nxt = bit_cnt_q + BIT_W'(1);
    end
    if (mode_chg) bit_cnt_nxt = '0;

    shreg_d   = shreg_nxt;
    bit_cnt_d = bit_cnt_nxt;
    data_d    = data_q;
    valid_d   = valid_q;
    if (valid_q && out_if.ready) valid_d = 1'b0;

    // The transfer looks at the post-shift word so the final bit reaches
    // data on the same edge it is collected, and a consumed word can be
    // replaced in the same cycle without a bubble.
    if ((bit_cnt_nxt == BIT_FULL) && (!valid_q || out_if.ready) &&
        !health_fail_d && !clear_fail) begin
      data_d    = shreg_nxt;
      valid_d   = 1'b1;
      bit_cnt_d = '0;
    end

    // A tripped health test withdraws any pending word on the trip edge.
    if (health_fail_d) valid_d = 1'b0;

    if (clear_fail) begin
      shreg_d   = '0;
      bit_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_cnt_q     <= '0;
      prev_q        <= 1'b0;
      rep_cnt_q     <= '0;
      health_fail_q <= 1'b0;
      mode_q        <= MODE_RAW;
      vn_state_q    <= VN_EMPTY;
      first_q       <= 1'b0;
      shreg_q       <= '0;
      bit_cnt_q     <= '0;
      data_q        <= '0;
      valid_q       <= 1'b0;
    end else begin
      smp_cnt_q     <= smp_cnt_d;
      prev_q        <= prev_d;
      rep_cnt_q     <= rep_cnt_d;
      health_fail_q <= health_fail_d;
      mode_q        <= mode_d;
      vn_state_q    <= vn_state_d;
      first_q       <= first_d;
      shreg_q       <= shreg_d;
      bit_cnt_q     <= bit_cnt_d;
      data_q        <= data_d;
      valid_q       <= valid_d;
    end
  end

  assign out_if.data  = data_q;
  assign out_if.valid = valid_q;
  assign health_fail  = health_fail_q;

endmodule

// File: tb/tb_trng_conditioner.sv
// Testbench for trng_conditioner: oscillator inputs are driven so that the
// XOR of the synchronised bits follows a chosen sample sequence; expected
// words are queued when their samples are driven and compared on output.
module tb_trng_conditioner;
  import trng_pkg::*;

  localparam int N_OSC      = 4;
  localparam int WORD_W     = 8;
  localparam int SAMPLE_DIV = 16;
  localparam int REP_LIMIT  = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             ena;
  logic [N_OSC-1:0] osc_in;
  trng_mode_t       mode;
  logic             clear_fail;
  logic             health_fail;

  int n_tests = 0;
  int n_fail  = 0;
  logic [WORD_W-1:0] sb[$];

  trng_conditioner_if #(.WORD_W(WORD_W)) vif ();

  trng_conditioner #(
    .N_OSC      (N_OSC),
    .WORD_W     (WORD_W),
    .SAMPLE_DIV (SAMPLE_DIV),
    .REP_LIMIT  (REP_LIMIT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .osc_in      (osc_in),
    .mode        (mode),
    .clear_fail  (clear_fail),
    .health_fail (health_fail),
    .out_if      (vif)
  );

  always #5 clk = ~clk;

  // Reset leaves the bench 1 time unit after a clock edge with the sample
  // counter at 0, so the next SAMPLE_DIV edges form one sample period.
  task automatic apply_reset(input trng_mode_t m);
    mode       = m;
    ena        = 1'b1;
    clear_fail = 1'b0;
    vif.ready  = 1'b0;
    rst_n      = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One sample period whose raw XOR bit is b, with random per-oscillator bits.
  task automatic sample(input logic b);
    logic [N_OSC-1:0] o;
    o      = N_OSC'($urandom);
    o[0]   = b ^ (^o[N_OSC-1:1]);
    osc_in = o;
    repeat (SAMPLE_DIV) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (vif.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", vif.valid); end
    n_tests++;
    if (vif.data !== '0) begin n_fail++; $display("FAIL reset_data: got %h expected 00", vif.data); end
    n_tests++;
    if (health_fail !== 1'b0) begin n_fail++; $display("FAIL reset_health: got %b expected 0", health_fail); end
    @(posedge clk); #1;
  endtask

  task automatic test_raw_word();
    logic [WORD_W-1:0] w, exp;
    w = 8'hAA;
    apply_reset(MODE_RAW);
    vif.ready = 1'b1;
    sb.push_back(w);
    for (int i = 0; i < WORD_W; i++) begin
      sample(w[WORD_W-1-i]);
      n_tests++;
      if (vif.valid !== (i == WORD_W - 1)) begin
        n_fail++; $display("FAIL raw_valid_s%0d: got %b expected %b", i, vif.valid, (i == WORD_W - 1));
      end
    end
    exp = sb.pop_front();
    n_tests++;
    if (vif.data !== exp) begin n_fail++; $display("FAIL raw_data: got %h expected %h", vif.data, exp); end
    @(posedge clk); #1;
    n_tests++;
    if (vif.valid !== 1'b0) begin n_fail++; $display("FAIL raw_valid_one_cycle: got %b expected 0", vif.valid); end
  endtask

  task automatic test_back_to_back();
    logic [2*WORD_W-1:0] bits;
    logic [WORD_W-1:0]   exp;
    bits = 16'h6996;
    apply_reset(MODE_RAW);
    vif.ready = 1'b1;
    sb.push_back(bits[15:8]);
    sb.push_back(bits[7:0]);
    for (int i = 0; i < 2 * WORD_W; i++) begin
      sample(bits[2*WORD_W-1-i]);
      n_tests++;
      if (vif.valid !== ((i % WORD_W) == WORD_W - 1)) begin
        n_fail++; $display("FAIL b2b_valid_s%0d: got %b expected %b", i, vif.valid, ((i % WORD_W) == WORD_W - 1));
      end
      if ((i % WORD_W) == WORD_W - 1) begin
        exp = sb.pop_front();
        n_tests++;
        if (vif.data !== exp) begin n_fail++; $display("FAIL b2b_data_s%0d: got %h expected %h", i, vif.data, exp); end
      end
    end
  endtask

  task automatic test_vn_debias();
    logic [19:0]       pairs;
    logic [WORD_W-1:0] exp;
    pairs = 20'b10_01_00_11_10_10_01_01_10_01;
    apply_reset(MODE_VN);
    vif.ready = 1'b1;
    sb.push_back(8'hB2);
    for (int i = 0; i < 20; i++) begin
      sample(pairs[19-i]);
      n_tests++;
      if (vif.valid !== (i == 19)) begin
        n_fail++; $display("FAIL vn_valid_s%0d: got %b expected %b", i, vif.valid, (i == 19));
      end
    end
    exp = sb.pop_front();
    n_tests++;
    if (vif.data !== exp) begin n_fail++; $display("FAIL vn_data: got %h expected %h", vif.data, exp); end
  endtask

  task automatic test_stall();
    logic [WORD_W-1:0] w [3];
    logic [WORD_W-1:0] exp;
    w[0] = 8'h5A; w[1] = 8'h3C; w[2] = 8'hC3;
    apply_reset(MODE_RAW);
    sb.push_back(w[0]);
    sb.push_back(w[1]);
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < WORD_W; i++) sample(w[k][WORD_W-1-i]);
      n_tests++;
      if ((vif.valid !== 1'b1) || (vif.data !== sb[0])) begin
        n_fail++; $display("FAIL stall_hold_w%0d: got valid=%b data=%h expected valid=1 data=%h", k, vif.valid, vif.data, sb[0]);
      end
    end
    vif.ready = 1'b1;
    exp = sb.pop_front();
    n_tests++;
    if (vif.data !== exp) begin n_fail++; $display("FAIL stall_first: got %h expected %h", vif.data, exp); end
    @(posedge clk); #1;
    exp = sb.pop_front();
    n_tests++;
    if ((vif.valid !== 1'b1) || (vif.data !== exp)) begin
      n_fail++; $display("FAIL stall_refill: got valid=%b data=%h expected valid=1 data=%h", vif.valid, vif.data, exp);
    end
    @(posedge clk); #1;
    n_tests++;
    if (vif.valid !== 1'b0) begin n_fail++; $display("FAIL stall_drained: got %b expected 0", vif.valid); end
  endtask

  task automatic test_health();
    logic [WORD_W-1:0] w, exp;
    w = 8'h9A;
    apply_reset(MODE_RAW);
    vif.ready = 1'b1;
    for (int i = 0; i < 3; i++) sb.push_back(8'hFF);
    for (int i = 1; i <= REP_LIMIT; i++) begin
      sample(1'b1);
      if ((i % WORD_W) == 0 && i < REP_LIMIT) begin
        exp = sb.pop_front();
        n_tests++;
        if ((vif.valid !== 1'b1) || (vif.data !== exp)) begin
          n_fail++; $display("FAIL health_word_s%0d: got valid=%b data=%h expected valid=1 data=%h", i, vif.valid, vif.data, exp);
        end
      end
      if (i == REP_LIMIT - 1) begin
        n_tests++;
        if (health_fail !== 1'b0) begin n_fail++; $display("FAIL health_early: got %b expected 0", health_fail); end
      end
    end
    n_tests++;
    if ((health_fail !== 1'b1) || (vif.valid !== 1'b0)) begin
      n_fail++; $display("FAIL health_trip: got fail=%b valid=%b expected fail=1 valid=0", health_fail, vif.valid);
    end
    clear_fail = 1'b1;
    @(posedge clk); #1;
    clear_fail = 1'b0;
    n_tests++;
    if (health_fail !== 1'b0) begin n_fail++; $display("FAIL health_clear: got %b expected 0", health_fail); end
    // Finish the current period with osc still at parity 1: first fresh bit.
    repeat (SAMPLE_DIV - 1) @(posedge clk);
    #1;
    sb.push_back(w);
    for (int i = 1; i < WORD_W; i++) begin
      n_tests++;
      if (vif.valid !== 1'b0) begin n_fail++; $display("FAIL health_refill_early_s%0d: got %b expected 0", i, vif.valid); end
      sample(w[WORD_W-1-i]);
    end
    exp = sb.pop_front();
    n_tests++;
    if ((vif.valid !== 1'b1) || (vif.data !== exp) || (health_fail !== 1'b0)) begin
      n_fail++; $display("FAIL health_refill: got valid=%b data=%h fail=%b expected valid=1 data=%h fail=0", vif.valid, vif.data, health_fail, exp);
    end
  endtask

  task automatic test_async_reset();
    logic [WORD_W-1:0] w0, w1, exp;
    w0 = 8'h5A; w1 = 8'hC6;
    apply_reset(MODE_RAW);
    sb.push_back(w0);
    for (int i = 0; i < WORD_W; i++) sample(w0[WORD_W-1-i]);
    exp = sb.pop_front();
    n_tests++;
    if ((vif.valid !== 1'b1) || (vif.data !== exp)) begin
      n_fail++; $display("FAIL arst_pre: got valid=%b data=%h expected valid=1 data=%h", vif.valid, vif.data, exp);
    end
    sample(1'b1); sample(1'b0); sample(1'b1); sample(1'b1);
    #3 rst_n = 1'b0;
    #1;
    n_tests++;
    if ((vif.valid !== 1'b0) || (vif.data !== '0) || (health_fail !== 1'b0)) begin
      n_fail++; $display("FAIL arst_immediate: got valid=%b data=%h fail=%b expected all 0", vif.valid, vif.data, health_fail);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    vif.ready = 1'b1;
    sb.push_back(w1);
    for (int i = 0; i < WORD_W; i++) begin
      sample(w1[WORD_W-1-i]);
      n_tests++;
      if (vif.valid !== (i == WORD_W - 1)) begin
        n_fail++; $display("FAIL arst_valid_s%0d: got %b expected %b", i, vif.valid, (i == WORD_W - 1));
      end
    end
    exp = sb.pop_front();
    n_tests++;
    if (vif.data !== exp) begin n_fail++; $display("FAIL arst_data: got %h expected %h", vif.data, exp); end
  endtask

  task automatic test_ena_pause();
    logic [WORD_W-1:0] w, exp;
    w = 8'h96;
    apply_reset(MODE_RAW);
    vif.ready = 1'b1;
    sb.push_back(w);
    for (int i = 0; i < 3; i++) sample(w[WORD_W-1-i]);
    ena = 1'b0;
    osc_in = N_OSC'($urandom);
    repeat (100) @(posedge clk);
    #1;
    n_tests++;
    if (vif.valid !== 1'b0) begin n_fail++; $display("FAIL ena_pause_valid: got %b expected 0", vif.valid); end
    ena = 1'b1;
    for (int i = 3; i < WORD_W; i++) begin
      sample(w[WORD_W-1-i]);
      n_tests++;
      if (vif.valid !== (i == WORD_W - 1)) begin
        n_fail++; $display("FAIL ena_valid_s%0d: got %b expected %b", i, vif.valid, (i == WORD_W - 1));
      end
    end
    exp = sb.pop_front();
    n_tests++;
    if (vif.data !== exp) begin n_fail++; $display("FAIL ena_data: got %h expected %h", vif.data, exp); end
  endtask

  task automatic test_mode_switch();
    logic [15:0]       pairs;
    logic [WORD_W-1:0] exp;
    pairs = 16'b01_10_10_01_10_01_01_10;
    apply_reset(MODE_RAW);
    vif.ready = 1'b1;
    sample(1'b1); sample(1'b0); sample(1'b1);
    mode = MODE_VN;
    sb.push_back(8'h69);
    for (int i = 0; i < 16; i++) begin
      sample(pairs[15-i]);
      n_tests++;
      if (vif.valid !== (i == 15)) begin
        n_fail++; $display("FAIL mode_valid_s%0d: got %b expected %b", i, vif.valid, (i == 15));
      end
    end
    exp = sb.pop_front();
    n_tests++;
    if (vif.data !== exp) begin n_fail++; $display("FAIL mode_data: got %h expected %h", vif.data, exp); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b1;
    ena        = 1'b1;
    mode       = MODE_RAW;
    clear_fail = 1'b0;
    osc_in     = '0;
    vif.ready  = 1'b0;
    #2;
    test_reset();
    test_raw_word();
    test_back_to_back();
    test_vn_debias();
    test_stall();
    test_health();
    test_async_reset();
    test_ena_pause();
    test_mode_switch();
    n_tests++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_empty: got %0d left expected 0", sb.size()); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
